// File: rtl/phtime_lanes.sv
// Multi-lane phase-time generator: phase_k = freq*(tcnt*NLANE+k) + phoff (mod 2^PW).
// Optional phase offset port and add stage controlled by macro PHTIME_PHOFF_EN.
module phtime_lanes #(
  parameter int unsigned FW    = 27,
  parameter int unsigned TW    = 27,
  parameter int unsigned PW    = 27,
  parameter int unsigned NLANE = 4,
  parameter int unsigned LAT   = 5
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [FW-1:0]       freq,
`ifdef PHTIME_PHOFF_EN
  input  logic [PW-1:0]       phoff,
`endif
  input  logic [TW-1:0]       tcnt,
  input  logic                gatein,
  output logic [NLANE*PW-1:0] phasetime,
  output logic                gateout,
  output logic                valid
);

  localparam int unsigned LB = $clog2(NLANE);
  localparam int unsigned MD = LAT - 3;
  localparam int unsigned DW = NLANE * PW;
  localparam int unsigned CW = $clog2(LAT + 1);

  logic [LAT-1:0] gate_sr;
  logic           gate_d;
  logic [PW-1:0]  tcnt_r;
  logic [PW-1:0]  freq_s;
  logic [DW-1:0]  prod_c;
  logic [DW-1:0]  prod_d;
  logic [DW-1:0]  sum_q;
  logic [CW-1:0]  vcnt;
  logic           primed_c;
`ifdef PHTIME_PHOFF_EN
  logic [PW-1:0]  phoff_s;
  logic [PW-1:0]  phoff_d;
`endif

  assign gate_d  = gate_sr[0];
  assign gateout = gate_sr[LAT-1];

  // Input stage; shadows reload only while the previous sampled gate was low
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gate_sr <= '0;
      tcnt_r  <= '0;
      freq_s  <= '0;
`ifdef PHTIME_PHOFF_EN
      phoff_s <= '0;
`endif
    end else begin
      gate_sr <= {gate_sr[LAT-2:0], gatein};
      tcnt_r  <= PW'(tcnt);
      if (!gate_d) begin
        freq_s  <= freq[PW-1:0];
`ifdef PHTIME_PHOFF_EN
        phoff_s <= phoff;
`endif
      end
    end
  end

  // Per-lane products, truncated to PW bits
  always_comb begin
    logic [PW-1:0] t_k;
    prod_c = '0;
    t_k    = '0;
    for (int k = 0; k < NLANE; k++) begin
      t_k = (tcnt_r << LB) + PW'(k);
      prod_c[k*PW +: PW] = freq_s * t_k;
    end
  end

  // Retiming registers behind the multiplier; offset travels alongside its word
  if (MD == 0) begin : g_nomd
    assign prod_d = prod_c;
`ifdef PHTIME_PHOFF_EN
    assign phoff_d = phoff_s;
`endif
  end else begin : g_md
    logic [MD-1:0][DW-1:0] prod_q;
`ifdef PHTIME_PHOFF_EN
    logic [MD-1:0][PW-1:0] phoff_q;
`endif
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        prod_q <= '0;
`ifdef PHTIME_PHOFF_EN
        phoff_q <= '0;
`endif
      end else begin
        prod_q[0] <= prod_c;
`ifdef PHTIME_PHOFF_EN
        phoff_q[0] <= phoff_s;
`endif
        for (int i = 1; i < MD; i++) begin
          prod_q[i] <= prod_q[i-1];
`ifdef PHTIME_PHOFF_EN
          phoff_q[i] <= phoff_q[i-1];
`endif
        end
      end
    end
    assign prod_d = prod_q[MD-1];
`ifdef PHTIME_PHOFF_EN
    assign phoff_d = phoff_q[MD-1];
`endif
  end

  // Offset add stage (plain register when the offset is disabled)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sum_q <= '0;
    end else begin
`ifdef PHTIME_PHOFF_EN
      for (int k = 0; k < NLANE; k++) begin
        sum_q[k*PW +: PW] <= prod_d[k*PW +: PW] + phoff_d;
      end
`else
      sum_q <= prod_d;
`endif
    end
  end

  assign primed_c = valid | (vcnt == CW'(LAT - 1));

  // Priming counter and zero-gated output register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vcnt      <= '0;
      valid     <= 1'b0;
      phasetime <= '0;
    end else begin
      if (!valid) begin
        vcnt <= vcnt + CW'(1);
      end
      valid     <= primed_c;
      phasetime <= primed_c ? sum_q : '0;
    end
  end

endmodule
